// File: rtl/alu_serial_exec.sv
// Execution unit fed by the ALU control decoder.
// Single-cycle ADD/SUB/AND/OR/XOR/SLT, and a serial shifter for SLL/SRL/SRA
// that moves one bit position per clock.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds valid and its payload stable until then.
// Ready never depends combinationally on valid.
module alu_serial_exec #(
    parameter  int DATA_W  = 32,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        alu_ctrl_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic [1:0]        state_o
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   work_q;
    logic [SHAMT_W-1:0]  cnt_q;

    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W-1:0]   shift_nxt;
    logic                is_shift;
    logic [SHAMT_W-1:0]  shamt;

    assign in_ready_o  = (state == S_IDLE);
    assign out_valid_o = (state == S_DONE);
    assign state_o     = state;
    assign shamt       = data2_i[SHAMT_W-1:0];
    assign is_shift    = (alu_ctrl_i == OP_SLL) || (alu_ctrl_i == OP_SRL) ||
                         (alu_ctrl_i == OP_SRA);

    // Single-cycle result from the request operands; unknown codes behave as ADD.
    always_comb begin
        alu_res = data1_i + data2_i;
        case (alu_ctrl_i)
            OP_AND:  alu_res = data1_i & data2_i;
            OP_OR:   alu_res = data1_i | data2_i;
            OP_XOR:  alu_res = data1_i ^ data2_i;
            OP_SUB:  alu_res = data1_i - data2_i;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                                ($signed(data1_i) < $signed(data2_i))};
            default: alu_res = data1_i + data2_i;
        endcase
    end

    // One-bit shift of the work register according to the latched opcode.
    always_comb begin
        shift_nxt = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
        case (op_q)
            OP_SLL:  shift_nxt = {work_q[DATA_W-2:0], 1'b0};
            OP_SRL:  shift_nxt = {1'b0, work_q[DATA_W-1:1]};
            default: shift_nxt = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
        endcase
    end

    // Control FSM with registered result/zero; counter holds remaining shifts.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            op_q     <= OP_ADD;
            work_q   <= '0;
            cnt_q    <= '0;
            result_o <= '0;
            zero_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        op_q <= alu_ctrl_i;
                        if (is_shift) begin
                            work_q <= data1_i;
                            cnt_q  <= shamt;
                            if (shamt == '0) begin
                                result_o <= data1_i;
                                zero_o   <= (data1_i == '0);
                                state    <= S_DONE;
                            end else begin
                                state <= S_SHIFT;
                            end
                        end else begin
                            result_o <= alu_res;
                            zero_o   <= (alu_res == '0);
                            state    <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    work_q <= shift_nxt;
                    cnt_q  <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_o <= shift_nxt;
                        zero_o   <= (shift_nxt == '0);
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Directed bench for alu_serial_exec: vector table plus backpressure and
// mid-shift reset sequences.
module tb_alu_serial_exec;

    logic        clk_i;
    logic        rst_n_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  alu_ctrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic [1:0]  state_o;

    int total;
    int bad;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        int          lat;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    alu_serial_exec #(.DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .alu_ctrl_i  (alu_ctrl_i),
        .data1_i     (data1_i),
        .data2_i     (data2_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .state_o     (state_o)
    );

    // Clock generation
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait for its result with out_ready_i held high.
    task automatic do_op(input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output logic zero, output int lat,
                         output logic rdy_in_done);
        @(negedge clk_i);
        alu_ctrl_i = ctrl;
        data1_i    = a;
        data2_i    = b;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        res         = result_o;
        zero        = zero_o;
        rdy_in_done = in_ready_o;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] res;
        logic        zero;
        logic        rdy;
        int          lat;

        total = 0;
        bad   = 0;

        vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1};
        vecs[1]  = '{4'b0110, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1};
        vecs[2]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
        vecs[3]  = '{4'b1000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};
        vecs[4]  = '{4'b1011, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 32};
        vecs[5]  = '{4'b1010, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 32};
        vecs[6]  = '{4'b1001, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020, 1'b0, 6};
        vecs[7]  = '{4'b1001, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[8]  = '{4'b1111, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1};
        vecs[9]  = '{4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1};
        vecs[10] = '{4'b1011, 32'hF000_0000, 32'h0000_0024, 32'hFF00_0000, 1'b0, 5};
        vecs[11] = '{4'b1010, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 1'b0, 5};
        vecs[12] = '{4'b1010, 32'hFFFF_FFFF, 32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[13] = '{4'b1001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 2};
        vecs[14] = '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1};

        in_valid_i  = 1'b0;
        alu_ctrl_i  = 4'b0000;
        data1_i     = '0;
        data2_i     = '0;
        out_ready_i = 1'b1;
        rst_n_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_zero", {31'b0, zero_o}, 32'd0);
        check("rst_state", {30'b0, state_o}, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, res, zero, lat, rdy);
            check($sformatf("v%0d_result", i), res, vecs[i].res);
            check($sformatf("v%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].zero});
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_ready_in_done", i), {31'b0, rdy}, 32'd0);
            check($sformatf("v%0d_valid_after", i), {31'b0, out_valid_o}, 32'd0);
            check($sformatf("v%0d_ready_after", i), {31'b0, in_ready_o}, 32'd1);
        end

        // Backpressure: XOR result held for 5 cycles, stray request ignored
        out_ready_i = 1'b0;
        @(negedge clk_i);
        alu_ctrl_i = 4'b0011;
        data1_i    = 32'h0000_F0F0;
        data2_i    = 32'h0000_FFFF;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        check("bp_valid_lat1", {31'b0, out_valid_o}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                alu_ctrl_i = 4'b0010;
                data1_i    = 32'h0000_0001;
                data2_i    = 32'h0000_0001;
                in_valid_i = 1'b1;
            end else begin
                in_valid_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            check($sformatf("bp_valid_c%0d", c), {31'b0, out_valid_o}, 32'd1);
            check($sformatf("bp_result_c%0d", c), result_o, 32'h0000_0F0F);
            check($sformatf("bp_ready_c%0d", c), {31'b0, in_ready_o}, 32'd0);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("bp_valid_drop", {31'b0, out_valid_o}, 32'd0);
        check("bp_result_kept", result_o, 32'h0000_0F0F);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("bp_no_extra_c%0d", c), {31'b0, out_valid_o}, 32'd0);
        end

        // Reset 3 cycles into an SRL by 20
        @(negedge clk_i);
        alu_ctrl_i = 4'b1010;
        data1_i    = 32'hFFFF_FFFF;
        data2_i    = 32'd20;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        check("mid_state_shift", {30'b0, state_o}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid_o}, 32'd0);
        check("mid_rst_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        check("mid_rel_ready", {31'b0, in_ready_o}, 32'd1);
        repeat (25) @(posedge clk_i);
        #1;
        check("mid_no_output", {31'b0, out_valid_o}, 32'd0);
        do_op(4'b0000, 32'h0000_FF00, 32'h0000_0FF0, res, zero, lat, rdy);
        check("and_result", res, 32'h0000_0F00);
        check("and_zero", {31'b0, zero}, 32'd0);
        check("and_latency", lat, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
